// File: rtl/stream_acc_pkg.sv
// Shared types and defaults for the block accumulator and its input FIFO.
package stream_acc_pkg;

   typedef enum logic [0:0] {
      S_ACC = 1'b0,
      S_OUT = 1'b1
   } acc_state_t;

   localparam int DATA_W_DEF     = 16;
   localparam int ACC_W_DEF      = 24;
   localparam int BLOCK_LEN_DEF  = 8;
   localparam int FIFO_DEPTH_DEF = 4;

   // True when a BLOCK_LEN-sample sum of DATA_W-bit words cannot overflow ACC_W bits.
   function automatic bit acc_w_fits(input int data_w, input int acc_w, input int block_len);
      return acc_w >= data_w + $clog2(block_len);
   endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO: registered storage, wrap-around pointers, async active-low reset.
module stream_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic [W-1:0]             pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];
   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;

endmodule

// File: rtl/stream_block_acc.sv
// Accumulates blocks of BLOCK_LEN unsigned samples and emits {block max, block sum} per block.
module stream_block_acc
   import stream_acc_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int BLOCK_LEN  = BLOCK_LEN_DEF,
   parameter int ACC_W      = ACC_W_DEF,
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                      csi_clk,
   input  logic                      rsi_reset_n,
   input  logic [DATA_W-1:0]         asi_in0_data,
   input  logic                      asi_in0_valid,
   output logic                      asi_in0_ready,
   output logic [DATA_W+ACC_W-1:0]   aso_out0_data,
   output logic                      aso_out0_valid,
   input  logic                      aso_out0_ready
);

   localparam int CNT_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
   localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

   if (!acc_w_fits(DATA_W, ACC_W, BLOCK_LEN)) begin : g_bad_acc_w
      $error("ACC_W is too narrow to hold a full block sum");
   end
   if (BLOCK_LEN < 2) begin : g_bad_block_len
      $error("BLOCK_LEN must be at least 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
   end

   acc_state_t state;
   acc_state_t state_nxt;

   logic                    push;
   logic                    pop;
   logic                    last_word;
   logic                    out_fire;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic [FCW-1:0]          fifo_count;
   logic [FCW-1:0]          count_nxt;
   logic [DATA_W-1:0]       word;
   logic [DATA_W-1:0]       max_q;
   logic [DATA_W-1:0]       max_nxt;
   logic [ACC_W-1:0]        acc_q;
   logic [ACC_W-1:0]        acc_nxt;
   logic [CNT_W-1:0]        cnt_q;
   logic                    in_ready_q;
   logic [DATA_W+ACC_W-1:0] out_data_q;

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   // Input ready is registered and never depends on input valid; output valid/data stay
   // frozen from the edge they are raised until the edge where the sink's ready is seen.
   assign push = asi_in0_valid && in_ready_q && !fifo_full;

   stream_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (csi_clk),
      .rst_n     (rsi_reset_n),
      .push      (push),
      .push_data (asi_in0_data),
      .pop       (pop),
      .pop_data  (word),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) state <= S_ACC;
      else              state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      last_word = 1'b0;
      out_fire  = 1'b0;
      case (state)
         S_ACC: begin
            pop       = !fifo_empty;
            last_word = pop && (cnt_q == CNT_LAST);
            if (last_word) state_nxt = S_OUT;
         end
         S_OUT: begin
            out_fire = aso_out0_ready;
            if (out_fire) state_nxt = S_ACC;
         end
         default: state_nxt = S_ACC;
      endcase
   end

   assign acc_nxt   = acc_q + ACC_W'(word);
   assign max_nxt   = (word > max_q) ? word : max_q;
   assign count_nxt = fifo_count + FCW'(push) - FCW'(pop);

   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         acc_q      <= '0;
         max_q      <= '0;
         cnt_q      <= '0;
         out_data_q <= '0;
         in_ready_q <= 1'b0;
      end else begin
         in_ready_q <= (count_nxt < FCW'(FIFO_DEPTH));
         if (out_fire) begin
            acc_q <= '0;
            max_q <= '0;
            cnt_q <= '0;
         end else if (pop) begin
            acc_q <= acc_nxt;
            max_q <= max_nxt;
            cnt_q <= last_word ? '0 : cnt_q + CNT_W'(1);
            if (last_word) out_data_q <= {max_nxt, acc_nxt};
         end
      end
   end

   assign asi_in0_ready  = in_ready_q;
   assign aso_out0_data  = out_data_q;
   assign aso_out0_valid = (state == S_OUT);

endmodule

// File: tb/tb_stream_block_acc.sv
// Scoreboard bench for stream_block_acc: directed blocks, back-pressure, reset, random streaming.
module tb_stream_block_acc;

   logic        csi_clk = 1'b0;
   logic        rsi_reset_n;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [39:0] out_data;
   logic        out_valid;
   logic        out_ready;

   logic [39:0] exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          push_cnt = 0;

   stream_block_acc #(
      .DATA_W     (16),
      .BLOCK_LEN  (8),
      .ACC_W      (24),
      .FIFO_DEPTH (4)
   ) dut (
      .csi_clk        (csi_clk),
      .rsi_reset_n    (rsi_reset_n),
      .asi_in0_data   (in_data),
      .asi_in0_valid  (in_valid),
      .asi_in0_ready  (in_ready),
      .aso_out0_data  (out_data),
      .aso_out0_valid (out_valid),
      .aso_out0_ready (out_ready)
   );

   // clock / watchdog
   always #5 csi_clk = ~csi_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   always @(posedge csi_clk) begin
      if (rsi_reset_n && in_valid && in_ready) push_cnt++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // driver: call at a negedge; returns at the negedge after the sample was accepted
   task automatic send(input logic [15:0] d);
      int n;
      n = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && n < 1000) begin
         @(negedge csi_clk);
         n++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: in_ready got 0, required 1");
      end
      @(negedge csi_clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 2000) begin
         @(negedge csi_clk);
         n++;
      end
      check(name, exp_q.size(), 0);
   endtask

   // monitor / scoreboard
   initial begin
      logic        prev_hold;
      logic [39:0] prev_data;
      prev_hold = 1'b0;
      prev_data = '0;
      forever begin
         @(negedge csi_clk);
         #1;
         if (!rsi_reset_n) begin
            check("reset_in_ready", in_ready, 0);
            check("reset_out_valid", out_valid, 0);
            check("reset_out_data", out_data, 0);
            prev_hold = 1'b0;
         end else begin
            if (prev_hold) begin
               check("hold_valid", out_valid, 1);
               check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_result: got %0h, required no result", out_data);
               end else begin
                  check("result", out_data, exp_q.pop_front());
               end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
         end
      end
   end

   // stimulus
   initial begin
      int          p0;
      int          n;
      logic [15:0] blk [8];
      logic [23:0] m_sum;
      logic [15:0] m_max;

      rsi_reset_n = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      out_ready   = 1'b1;
      repeat (3) @(negedge csi_clk);
      rsi_reset_n = 1'b1;
      check("ready_at_release", in_ready, 0);
      @(negedge csi_clk);
      check("ready_after_edge", in_ready, 1);

      // 1: samples 1..8, latency and single-cycle valid
      exp_q.push_back({16'd8, 24'd36});
      for (int i = 1; i <= 8; i++) send(16'(i));
      check("t1_valid_before", out_valid, 0);
      @(negedge csi_clk);
      check("t1_valid_2_edges", out_valid, 1);
      check("t1_data", out_data, {16'd8, 24'd36});
      @(negedge csi_clk);
      check("t1_valid_1_cycle", out_valid, 0);
      wait_drain("t1_drain");

      // 2: worst-case width, then an all-zero block
      exp_q.push_back({16'hFFFF, 24'h07FFF8});
      for (int i = 0; i < 8; i++) send(16'hFFFF);
      exp_q.push_back({16'h0000, 24'h000000});
      for (int i = 0; i < 8; i++) send(16'h0000);
      wait_drain("t2_drain");

      // 3: back-pressure with samples 1..16
      p0 = push_cnt;
      out_ready = 1'b0;
      exp_q.push_back({16'd8, 24'd36});
      exp_q.push_back({16'd16, 24'd100});
      fork
         begin
            for (int i = 1; i <= 16; i++) send(16'(i));
         end
         begin
            n = 0;
            while (!out_valid && n < 100) begin
               @(negedge csi_clk);
               n++;
            end
            check("t3_valid_seen", out_valid, 1);
            repeat (30) @(negedge csi_clk);
            check("t3_in_ready_low", in_ready, 0);
            check("t3_accepts", push_cnt - p0, 12);
            check("t3_held_data", out_data, {16'd8, 24'd36});
            out_ready = 1'b1;
         end
      join
      wait_drain("t3_drain");

      // 4: reset in the middle of a block
      for (int i = 0; i < 3; i++) send(16'd7);
      rsi_reset_n = 1'b0;
      repeat (2) @(negedge csi_clk);
      rsi_reset_n = 1'b1;
      check("t4_ready_at_release", in_ready, 0);
      exp_q.push_back({16'd2, 24'd16});
      for (int i = 0; i < 8; i++) send(16'd2);
      wait_drain("t4_drain");

      // 5: 100 blocks with random input gaps and random output stalls
      begin
         bit done;
         done = 1'b0;
         fork
            begin
               for (int b = 0; b < 100; b++) begin
                  m_sum = '0;
                  m_max = '0;
                  for (int s = 0; s < 8; s++) begin
                     blk[s] = (b % 10 == 3) ? 16'hFFFF : 16'($urandom_range(0, 65535));
                     m_sum  = m_sum + 24'(blk[s]);
                     if (blk[s] > m_max) m_max = blk[s];
                  end
                  exp_q.push_back({m_max, m_sum});
                  for (int s = 0; s < 8; s++) begin
                     send(blk[s]);
                     repeat ($urandom_range(0, 2)) @(negedge csi_clk);
                  end
               end
               done = 1'b1;
            end
            begin
               while (!done) begin
                  out_ready = ($urandom_range(0, 3) != 0);
                  @(negedge csi_clk);
               end
               out_ready = 1'b1;
            end
         join
      end
      wait_drain("t5_drain");

      repeat (3) @(negedge csi_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
